// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: grants up to two register-file writes per cycle in
// round-robin order, never two to one register, and stages them for ports 3/6.
module wb_write_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Handshake: requester i transfers on a clock edge where req_valid[i] &
  // req_ready[i]. req_ready is combinational from the requests; requesters
  // hold valid/addr/data stable until then, and valid never depends on ready.
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 we3,
  output logic [AW-1:0]        a3,
  output logic [DW-1:0]        wd3,
  output logic                 we6,
  output logic [AW-1:0]        a6,
  output logic [DW-1:0]        wd6,
  output logic [2**AW-1:0]     pend_mask
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] is_x0;
  logic [NREQ-1:0] grant;

  logic            slot_a_vld;
  logic [PW-1:0]   slot_a_idx;
  logic [AW-1:0]   slot_a_addr;
  logic [DW-1:0]   slot_a_data;
  logic            slot_b_vld;
  logic [PW-1:0]   slot_b_idx;
  logic [AW-1:0]   slot_b_addr;
  logic [DW-1:0]   slot_b_data;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + PW'(1);
  endfunction

  always_comb begin : classify
    elig  = '0;
    is_x0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      is_x0[i] = req_valid[i] && (req_addr[i*AW +: AW] == '0);
      elig[i]  = req_valid[i] && (req_addr[i*AW +: AW] != '0);
    end
  end

  // Single pass in scan order: the first eligible owner takes slot A, the
  // next eligible one with a different destination takes slot B.
  always_comb begin : scan
    int idx;
    idx         = 0;
    slot_a_vld  = 1'b0;
    slot_a_idx  = '0;
    slot_a_addr = '0;
    slot_a_data = '0;
    slot_b_vld  = 1'b0;
    slot_b_idx  = '0;
    slot_b_addr = '0;
    slot_b_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx]) begin
        if (!slot_a_vld) begin
          slot_a_vld  = 1'b1;
          slot_a_idx  = PW'(idx);
          slot_a_addr = req_addr[idx*AW +: AW];
          slot_a_data = req_data[idx*DW +: DW];
        end else if (!slot_b_vld && (req_addr[idx*AW +: AW] != slot_a_addr)) begin
          slot_b_vld  = 1'b1;
          slot_b_idx  = PW'(idx);
          slot_b_addr = req_addr[idx*AW +: AW];
          slot_b_data = req_data[idx*DW +: DW];
        end
      end
    end
  end

  always_comb begin : grant_logic
    grant   = '0;
    ptr_nxt = ptr;
    if (slot_a_vld) begin
      grant[slot_a_idx] = 1'b1;
      ptr_nxt           = wrap_inc(slot_a_idx);
    end
    if (slot_b_vld) begin
      grant[slot_b_idx] = 1'b1;
      ptr_nxt           = wrap_inc(slot_b_idx);
    end
  end

  // x0 writes are acknowledged without consuming a port.
  assign req_ready = rst_n ? (grant | is_x0) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
      we6 <= 1'b0;
      a6  <= '0;
      wd6 <= '0;
    end else begin
      ptr <= ptr_nxt;
      we3 <= slot_a_vld;
      a3  <= slot_a_addr;
      wd3 <= slot_a_data;
      we6 <= slot_b_vld;
      a6  <= slot_b_addr;
      wd6 <= slot_b_data;
    end
  end

  always_comb begin : pending
    pend_mask = '0;
    if (we3) pend_mask[a3] = 1'b1;
    if (we6) pend_mask[a6] = 1'b1;
  end

  a_distinct_ports: assert property (@(posedge clk) disable iff (!rst_n)
    (we3 && we6) |-> (a3 != a6));
  a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
    (!we3 || a3 != '0) && (!we6 || a6 != '0));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based arbitration model and a register-file model.
module tb_wb_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int SW   = 2 * (1 + AW + DW);

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                we3, we6;
  logic [AW-1:0]       a3, a6;
  logic [DW-1:0]       wd3, wd6;
  logic [2**AW-1:0]    pend_mask;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] exp_q[$];
  logic [DW-1:0] rf [2**AW];

  // model state and outputs
  int              m_ptr;
  int              m_next;
  logic [NREQ-1:0] m_ready;
  logic            m_wa, m_wb;
  logic [AW-1:0]   m_aa, m_ab;
  logic [DW-1:0]   m_da, m_db;

  wb_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we3(we3), .a3(a3), .wd3(wd3),
    .we6(we6), .a6(a6), .wd6(wd6),
    .pend_mask(pend_mask)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file fed by the write ports
  initial for (int r = 0; r < 2**AW; r++) rf[r] = '0;
  always @(posedge clk) begin
    if (we3) rf[a3] <= wd3;
    if (we6) rf[a6] <= wd6;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input bit v, input int a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = AW'(a);
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  function automatic int addr_of(input int i);
    return int'(req_addr[i*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  // Reference: list the valid requesters in pointer order, ack the x0 ones,
  // then take the head of the remaining list for A and the first later entry
  // with a different destination for B.
  task automatic model_eval();
    int cand[$];
    int i;
    int a;
    m_ready = '0;
    m_wa = 1'b0; m_aa = '0; m_da = '0;
    m_wb = 1'b0; m_ab = '0; m_db = '0;
    m_next = m_ptr;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) begin
        if (addr_of(i) == 0) m_ready[i] = 1'b1;
        else cand.push_back(i);
      end
    end
    if (cand.size() > 0) begin
      a = cand.pop_front();
      m_ready[a] = 1'b1;
      m_wa = 1'b1; m_aa = AW'(addr_of(a)); m_da = data_of(a);
      m_next = (a + 1) % NREQ;
      while (cand.size() > 0) begin
        i = cand.pop_front();
        if (addr_of(i) != int'(m_aa)) begin
          m_ready[i] = 1'b1;
          m_wb = 1'b1; m_ab = AW'(addr_of(i)); m_db = data_of(i);
          m_next = (i + 1) % NREQ;
          break;
        end
      end
    end
  endtask

  task automatic new_req(input int i);
    int a;
    if ($urandom_range(0, 4) == 0) a = 0;
    else if ($urandom_range(0, 2) == 0) a = $urandom_range(1, 2**AW - 1);
    else a = $urandom_range(1, 3);
    set_req(i, ($urandom_range(0, 3) != 0), a, $urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 32'hA0 + i);
    rst_n = 1'b0;
    #3;
    checks++;
    if ({we3, a3, wd3, we6, a6, wd6} !== '0) begin
      errors++;
      $display("FAIL reset_ports: got we3=%0b a3=%0d wd3=%h we6=%0b a6=%0d wd6=%h, want all 0",
               we3, a3, wd3, we6, a6, wd6);
    end
    checks++;
    if (pend_mask !== '0) begin
      errors++; $display("FAIL reset_pend: got %h want 0", pend_mask);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (we3 !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_hold: got we3=%0b ready=%b want 0/0000", we3, req_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0011) begin
      errors++; $display("FAIL reset_first_ready: got %b want 0011", req_ready);
    end
    advance();
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd1 || we6 !== 1'b1 || a6 !== 5'd2) begin
      errors++;
      $display("FAIL reset_first_grant: got we3=%0b a3=%0d we6=%0b a6=%0d want 1/1/1/2",
               we3, a3, we6, a6);
    end
    clear_reqs();
  endtask

  task automatic test_dual_grant();
    clear_reqs();
    do_reset();
    set_req(0, 1'b1, 5, 32'h11);
    set_req(2, 1'b1, 7, 32'h22);
    #1;
    checks++;
    if (req_ready !== 4'b0101) begin
      errors++; $display("FAIL dual_ready: got %b want 0101", req_ready);
    end
    advance();
    clear_reqs();
    checks++;
    if ({we3, a3, wd3} !== {1'b1, 5'd5, 32'h11} || {we6, a6, wd6} !== {1'b1, 5'd7, 32'h22}) begin
      errors++;
      $display("FAIL dual_ports: got %0b/%0d/%h %0b/%0d/%h want 1/5/11 1/7/22",
               we3, a3, wd3, we6, a6, wd6);
    end
    checks++;
    if (pend_mask !== 32'h0000_00A0) begin
      errors++; $display("FAIL dual_pend: got %h want 000000a0", pend_mask);
    end
    advance();
    checks++;
    if (rf[5] !== 32'h11 || rf[7] !== 32'h22) begin
      errors++; $display("FAIL dual_rf: got x5=%h x7=%h want 11/22", rf[5], rf[7]);
    end
  endtask

  task automatic test_conflict();
    clear_reqs();
    do_reset();
    set_req(0, 1'b1, 9, 32'h90);
    set_req(1, 1'b1, 9, 32'h91);
    set_req(3, 1'b1, 4, 32'h43);
    #1;
    checks++;
    if (req_ready !== 4'b1001) begin
      errors++; $display("FAIL conflict_ready: got %b want 1001", req_ready);
    end
    advance();
    set_req(0, 1'b0, 0, '0);
    set_req(3, 1'b0, 0, '0);
    checks++;
    if ({we3, a3, wd3} !== {1'b1, 5'd9, 32'h90} || {we6, a6, wd6} !== {1'b1, 5'd4, 32'h43}) begin
      errors++;
      $display("FAIL conflict_ports: got %0b/%0d/%h %0b/%0d/%h want 1/9/90 1/4/43",
               we3, a3, wd3, we6, a6, wd6);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL conflict_retry_ready: got %b want 0010", req_ready);
    end
    advance();
    clear_reqs();
    checks++;
    if ({we3, a3, wd3, we6} !== {1'b1, 5'd9, 32'h91, 1'b0}) begin
      errors++;
      $display("FAIL conflict_retry_port: got %0b/%0d/%h we6=%0b want 1/9/91 0", we3, a3, wd3, we6);
    end
  endtask

  task automatic test_x0_discard();
    clear_reqs();
    do_reset();
    set_req(1, 1'b1, 0, 32'hDEAD);
    set_req(2, 1'b1, 3, 32'h33);
    #1;
    checks++;
    if (req_ready !== 4'b0110) begin
      errors++; $display("FAIL x0_ready: got %b want 0110", req_ready);
    end
    advance();
    clear_reqs();
    checks++;
    if ({we3, a3, wd3, we6} !== {1'b1, 5'd3, 32'h33, 1'b0}) begin
      errors++; $display("FAIL x0_ports: got %0b/%0d/%h we6=%0b want 1/3/33 0", we3, a3, wd3, we6);
    end
    // with ptr=3 the scan starts at req3, so req3 wins port 3 over req0
    set_req(0, 1'b1, 10, 32'hA0);
    set_req(3, 1'b1, 11, 32'hB3);
    advance();
    clear_reqs();
    checks++;
    if (a3 !== 5'd11 || a6 !== 5'd10 || we3 !== 1'b1 || we6 !== 1'b1) begin
      errors++; $display("FAIL x0_ptr: got a3=%0d a6=%0d want 11/10", a3, a6);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] pair_tbl [4];
    logic [NREQ-1:0] single_tbl [4];
    pair_tbl   = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    single_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    clear_reqs();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 12 + i, 32'hF0 + i);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== pair_tbl[c]) begin
        errors++; $display("FAIL fair_pair[%0d]: got %b want %b", c, req_ready, pair_tbl[c]);
      end
      advance();
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8, 32'h80 + i);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== single_tbl[c]) begin
        errors++; $display("FAIL fair_single[%0d]: got %b want %b", c, req_ready, single_tbl[c]);
      end
      advance();
      checks++;
      if (wd3 !== 32'h80 + c || we6 !== 1'b0) begin
        errors++; $display("FAIL fair_single_port[%0d]: got wd3=%h we6=%0b want %h/0", c, wd3, we6, 32'h80 + c);
      end
    end
    clear_reqs();
  endtask

  task automatic test_async_reset();
    clear_reqs();
    do_reset();
    set_req(0, 1'b1, 6, 32'hAB);
    advance();
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd6) begin
      errors++; $display("FAIL async_staged: got we3=%0b a3=%0d want 1/6", we3, a3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (we3 !== 1'b0 || pend_mask !== '0) begin
      errors++; $display("FAIL async_drop: got we3=%0b pend=%h want 0/0", we3, pend_mask);
    end
    advance();
    checks++;
    if (rf[6] !== 32'h0) begin
      errors++; $display("FAIL async_no_write: got x6=%h want 0", rf[6]);
    end
    rst_n = 1'b1;
    advance();
    clear_reqs();
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd6 || wd3 !== 32'hAB) begin
      errors++; $display("FAIL async_retry: got %0b/%0d/%h want 1/6/ab", we3, a3, wd3);
    end
    advance();
    checks++;
    if (rf[6] !== 32'hAB) begin
      errors++; $display("FAIL async_retry_rf: got x6=%h want ab", rf[6]);
    end
  endtask

  task automatic test_random();
    logic [SW-1:0]     exp_v;
    logic [SW-1:0]     got_v;
    logic [2**AW-1:0]  exp_m;
    logic [NREQ-1:0]   took;
    clear_reqs();
    do_reset();
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) new_req(i);
    for (int c = 0; c < 400; c++) begin
      #1;
      model_eval();
      checks++;
      if (req_ready !== m_ready) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, m_ready);
      end
      exp_q.push_back({m_wa, m_aa, m_da, m_wb, m_ab, m_db});
      took = req_valid & m_ready;
      advance();
      m_ptr = m_next;
      exp_v = exp_q.pop_front();
      got_v = {we3, a3, wd3, we6, a6, wd6};
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL rand_ports[%0d]: got %h want %h", c, got_v, exp_v);
      end
      exp_m = '0;
      if (exp_v[SW-1])        exp_m[exp_v[SW-2 -: AW]] = 1'b1;
      if (exp_v[SW/2-1])      exp_m[exp_v[SW/2-2 -: AW]] = 1'b1;
      checks++;
      if (pend_mask !== exp_m) begin
        errors++; $display("FAIL rand_pend[%0d]: got %h want %h", c, pend_mask, exp_m);
      end
      for (int i = 0; i < NREQ; i++)
        if (took[i] || !req_valid[i]) new_req(i);
    end
    clear_reqs();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #12;
    test_reset();
    test_dual_grant();
    test_conflict();
    test_x0_discard();
    test_fairness();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
